// File: rtl/iir_coeff_loader.sv
// Double-buffered coefficient loader for two cascaded biquads: a 10-word frame fills a shadow bank.
// Latency: the shadow bank is committed to the active outputs at the first sample_tick after the frame completes.
// Backpressure: wr_ready drops only while a completed frame waits for a sample_tick.
module iir_coeff_loader #(
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic signed [COEFF_WIDTH-1:0] wr_data,
  input  logic                          wr_last,
  output logic                          wr_ready,
  input  logic                          sample_tick,
  output logic signed [COEFF_WIDTH-1:0] b0_1,
  output logic signed [COEFF_WIDTH-1:0] b1_1,
  output logic signed [COEFF_WIDTH-1:0] b2_1,
  output logic signed [COEFF_WIDTH-1:0] a1_1,
  output logic signed [COEFF_WIDTH-1:0] a2_1,
  output logic signed [COEFF_WIDTH-1:0] b0_2,
  output logic signed [COEFF_WIDTH-1:0] b1_2,
  output logic signed [COEFF_WIDTH-1:0] b2_2,
  output logic signed [COEFF_WIDTH-1:0] a1_2,
  output logic signed [COEFF_WIDTH-1:0] a2_2,
  output logic                          load_busy,
  output logic                          swap_done,
  output logic                          frame_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Unity gain in the coefficient Q format; b0 of each stage resets to this.
  localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(1) << COEFF_FRAC;

  logic [1:0] state;
  logic [3:0] idx;
  logic signed [COEFF_WIDTH-1:0] shadow [10];
  logic signed [COEFF_WIDTH-1:0] active [10];

  logic fire;
  logic last_pos;
  logic bad_last;
  logic do_swap;

  // Ready is a pure state decode, forced low while reset is held.
  assign wr_ready  = rst && (state != S_WAIT);
  assign load_busy = (state != S_IDLE);
  assign fire      = wr_valid && wr_ready;
  assign last_pos  = (idx == 4'd9);
  // In IDLE idx is 0, so a wr_last on the first word lands here as an error too.
  assign bad_last  = (wr_last != last_pos);
  assign do_swap   = (state == S_WAIT) && sample_tick;

  // Frame sequencing: word index, state transitions and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (fire) begin
            if (bad_last) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
              idx       <= 4'd0;
            end else if (last_pos) begin
              state <= S_WAIT;
              idx   <= 4'd0;
            end else begin
              state <= S_LOAD;
              idx   <= idx + 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (sample_tick) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          idx   <= 4'd0;
        end
      endcase
    end
  end

  // Shadow bank captures each accepted word at the current index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 10; i++) shadow[i] <= (i == 0 || i == 5) ? ONE : '0;
    end else if (fire) begin
      shadow[idx] <= wr_data;
    end
  end

  // Active bank swaps atomically from the shadow bank on a tick in WAIT_TICK.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 10; i++) active[i] <= (i == 0 || i == 5) ? ONE : '0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) active <= shadow;
    end
  end

  assign b0_1 = active[0];
  assign b1_1 = active[1];
  assign b2_1 = active[2];
  assign a1_1 = active[3];
  assign a2_1 = active[4];
  assign b0_2 = active[5];
  assign b1_2 = active[6];
  assign b2_2 = active[7];
  assign a1_2 = active[8];
  assign a2_2 = active[9];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: reset defaults, good frames, throttled input,
// malformed frames, tick coincidence and reset aborts, each checked against hand-built banks.
module tb_iir_coeff_loader;

  typedef logic [15:0] bank_t [10];

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        sample_tick;
  logic [15:0] b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2;
  logic        load_busy, swap_done, frame_err;

  logic [15:0] outs [10];
  bank_t passthru, exp_a, exp_b, exp_c, exp_d, exp_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iir_coeff_loader #(.COEFF_WIDTH(16), .COEFF_FRAC(14)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .sample_tick(sample_tick),
    .b0_1(b0_1), .b1_1(b1_1), .b2_1(b2_1), .a1_1(a1_1), .a2_1(a2_1),
    .b0_2(b0_2), .b1_2(b1_2), .b2_2(b2_2), .a1_2(a1_2), .a2_2(a2_2),
    .load_busy(load_busy), .swap_done(swap_done), .frame_err(frame_err)
  );

  assign outs[0] = b0_1; assign outs[1] = b1_1; assign outs[2] = b2_1;
  assign outs[3] = a1_1; assign outs[4] = a2_1; assign outs[5] = b0_2;
  assign outs[6] = b1_2; assign outs[7] = b2_2; assign outs[8] = a1_2;
  assign outs[9] = a2_2;

  function automatic int bank_diff(input bank_t e);
    int n = 0;
    for (int i = 0; i < 10; i++) if (outs[i] !== e[i]) n++;
    return n;
  endfunction

  task automatic fill(input logic [15:0] base, output bank_t b);
    for (int i = 0; i < 10; i++) b[i] = base + 16'(i);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [15:0] d, input logic l, input logic tk);
    wr_valid = 1'b1; wr_data = d; wr_last = l; sample_tick = tk;
    step();
    wr_valid = 1'b0; wr_last = 1'b0; sample_tick = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; wr_last = 1'b0; sample_tick = 1'b0;
    repeat (2) step();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", wr_ready); end
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", load_busy); end
    checks++; if (swap_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: swap_done=%b frame_err=%b want 0 0", swap_done, frame_err); end
    checks++; if (bank_diff(passthru) != 0) begin errors++; $display("FAIL rst_bank: b0_1=%h b1_1=%h b0_2=%h want 4000 0000 4000", b0_1, b1_1, b0_2); end
    rst = 1'b1;
    step();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", wr_ready); end
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", load_busy); end
    checks++; if (bank_diff(passthru) != 0) begin errors++; $display("FAIL release_bank: b0_1=%h want 4000", b0_1); end
  endtask

  task automatic test_good_frame();
    for (int i = 0; i < 10; i++) put(16'h0101 + 16'(i), i == 9, 1'b0);
    checks++; if (load_busy !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL wait_state: busy=%b ready=%b want 1 0", load_busy, wr_ready); end
    checks++; if (bank_diff(passthru) != 0) begin errors++; $display("FAIL early_swap: b0_1=%h want 4000", b0_1); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bank_diff(passthru) != 0 || swap_done !== 1'b0) begin errors++; $display("FAIL hold_before_tick: cycle %0d b0_1=%h swap_done=%b want 4000 0", c, b0_1, swap_done); end
    end
    tick();
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL swap_pulse: got %b want 1", swap_done); end
    checks++; if (bank_diff(exp_a) != 0) begin errors++; $display("FAIL bank_a: b0_1=%h a2_2=%h want 0101 010a", b0_1, a2_2); end
    checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL idle_after_swap: busy=%b want 0", load_busy); end
    step();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_single: got %b want 0", swap_done); end
  endtask

  task automatic test_toggle_valid();
    for (int i = 0; i < 10; i++) begin
      put(16'h0201 + 16'(i), i == 9, 1'b0);
      // Garbage on the data/last lines with valid low must be ignored.
      wr_data = 16'hDEAD; wr_last = 1'b1;
      step();
      wr_last = 1'b0;
      checks++; if (wr_ready !== (i < 9)) begin errors++; $display("FAIL toggle_ready: word %0d got %b want %b", i, wr_ready, i < 9); end
    end
    tick();
    checks++; if (swap_done !== 1'b1 || bank_diff(exp_b) != 0) begin errors++; $display("FAIL bank_b: swap_done=%b b0_1=%h a2_2=%h want 1 0201 020a", swap_done, b0_1, a2_2); end
  endtask

  task automatic test_frame_errors();
    for (int i = 0; i < 6; i++) put(16'h0501 + 16'(i), i == 5, 1'b0);
    checks++; if (frame_err !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("FAIL early_last: frame_err=%b busy=%b want 1 0", frame_err, load_busy); end
    step();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL err_single: got %b want 0", frame_err); end
    checks++; if (bank_diff(exp_b) != 0) begin errors++; $display("FAIL err_bank_kept: b0_1=%h want 0201", b0_1); end
    tick();
    checks++; if (swap_done !== 1'b0 || bank_diff(exp_b) != 0) begin errors++; $display("FAIL idle_tick: swap_done=%b b0_1=%h want 0 0201", swap_done, b0_1); end
    put(16'h0600, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1 || load_busy !== 1'b0) begin errors++; $display("FAIL single_word: frame_err=%b busy=%b want 1 0", frame_err, load_busy); end
    step();
    for (int i = 0; i < 10; i++) put(16'h0801 + 16'(i), 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1 || load_busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL missing_last: frame_err=%b busy=%b ready=%b want 1 0 1", frame_err, load_busy, wr_ready); end
    step();
    for (int i = 0; i < 10; i++) put(16'h0301 + 16'(i), i == 9, 1'b0);
    tick();
    checks++; if (swap_done !== 1'b1 || bank_diff(exp_c) != 0) begin errors++; $display("FAIL bank_c: swap_done=%b b0_1=%h a2_2=%h want 1 0301 030a", swap_done, b0_1, a2_2); end
  endtask

  task automatic test_tick_coincident();
    for (int i = 0; i < 10; i++) begin
      put(16'h0401 + 16'(i), i == 9, (i == 3) || (i == 9));
      if (i == 3) begin
        checks++; if (swap_done !== 1'b0 || bank_diff(exp_c) != 0) begin errors++; $display("FAIL load_tick: swap_done=%b b0_1=%h want 0 0301", swap_done, b0_1); end
      end
    end
    checks++; if (swap_done !== 1'b0 || bank_diff(exp_c) != 0 || load_busy !== 1'b1) begin errors++; $display("FAIL coincident_tick: swap_done=%b b0_1=%h busy=%b want 0 0301 1", swap_done, b0_1, load_busy); end
    step();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL coincident_late: swap_done=%b want 0", swap_done); end
    tick();
    checks++; if (swap_done !== 1'b1 || bank_diff(exp_d) != 0) begin errors++; $display("FAIL bank_d: swap_done=%b b0_1=%h a2_2=%h want 1 0401 040a", swap_done, b0_1, a2_2); end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 10; i++) put(16'h0701 + 16'(i), i == 9, 1'b0);
    checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL pre_abort_busy: got %b want 1", load_busy); end
    rst = 1'b0;
    step();
    checks++; if (wr_ready !== 1'b0 || load_busy !== 1'b0 || bank_diff(passthru) != 0) begin errors++; $display("FAIL wait_reset: ready=%b busy=%b b0_1=%h b1_1=%h want 0 0 4000 0000", wr_ready, load_busy, b0_1, b1_1); end
    rst = 1'b1;
    step();
    tick();
    checks++; if (swap_done !== 1'b0 || bank_diff(passthru) != 0) begin errors++; $display("FAIL tick_after_abort: swap_done=%b b0_1=%h want 0 4000", swap_done, b0_1); end
    // Reset mid-load must restart indexing at word 0.
    for (int i = 0; i < 4; i++) put(16'h0901 + 16'(i), 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 10; i++) put(16'h0A01 + 16'(i), i == 9, 1'b0);
    tick();
    checks++; if (swap_done !== 1'b1 || bank_diff(exp_f) != 0) begin errors++; $display("FAIL bank_after_load_reset: swap_done=%b b0_1=%h a2_2=%h want 1 0a01 0a0a", swap_done, b0_1, a2_2); end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) passthru[i] = (i == 0 || i == 5) ? 16'h4000 : 16'h0000;
    fill(16'h0101, exp_a);
    fill(16'h0201, exp_b);
    fill(16'h0301, exp_c);
    fill(16'h0401, exp_d);
    fill(16'h0A01, exp_f);
    test_reset();
    test_good_frame();
    test_toggle_valid();
    test_frame_errors();
    test_tick_coincident();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 Parameter COEFF_WIDTH, default 16: width of each signed coefficient word.
REQ-002 Parameter COEFF_FRAC, default 14: fractional bits of the coefficient Q format; 1.0 = 1<<COEFF_FRAC.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on clk rising edge; rst=0 resets.
REQ-005 wr_valid  input  1  upstream coefficient word valid.
REQ-006 wr_data  input  COEFF_WIDTH signed  coefficient word.
REQ-007 wr_last  input  1  marks final word of a load frame; qualified by wr_valid.
REQ-008 wr_ready  output  1  loader can accept a word this cycle.
REQ-009 sample_tick  input  1  one-cycle strobe at each filter sample boundary; the only instant an active-bank swap occurs.
REQ-010 b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2  output  COEFF_WIDTH signed each  active coefficient bank driving the two cascaded biquads directly.
REQ-011 load_busy  output  1  high whenever the FSM is not IDLE.
REQ-012 swap_done  output  1  one-cycle pulse, high in the cycle the new active bank first appears on the coefficient outputs.
REQ-013 frame_err  output  1  one-cycle pulse flagging a malformed frame.

Function
REQ-014 Frame = exactly 10 words, in order b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2; wr_last is high on word 10 only.
REQ-015 Transfer = wr_valid && wr_ready at a rising edge; the word is written into shadow register [idx], and idx increments.
REQ-016 FSM states: IDLE, LOAD, WAIT_TICK.
REQ-017 wr_ready = 1 in IDLE and LOAD, 0 in WAIT_TICK; wr_ready is a registered or pure state decode and does not depend combinationally on wr_valid.
REQ-018 IDLE: idx = 0; first transfer writes shadow[0] and moves to LOAD with idx = 1.
REQ-019 LOAD: each transfer writes shadow[idx].
- idx < 9, wr_last = 0: idx++.
- idx = 9, wr_last = 1: go to WAIT_TICK.
REQ-020 Error: wr_last = 1 with idx < 9, or wr_last = 0 with idx = 9 -> frame_err pulses the next cycle, FSM returns to IDLE, idx = 0, active bank untouched. Shadow contents are don't-care until the next good frame.
REQ-021 A single-word frame (wr_last on the first word, accepted in IDLE) is an error per REQ-020.
REQ-022 WAIT_TICK, sample_tick = 1: all 10 active registers load from shadow at that edge; swap_done = 1 in the following cycle; FSM goes to IDLE.
REQ-023 A sample_tick in the same cycle as the final (10th) transfer is ignored; the swap occurs on the next sample_tick seen in WAIT_TICK.
REQ-024 sample_tick in IDLE or LOAD has no effect.
REQ-025 Active registers change only per REQ-022 or reset; never partially; coefficient outputs are glitch-free register outputs.
REQ-026 No arithmetic on coefficients; words pass bit-exact from wr_data to outputs.
REQ-027 wr_data and wr_last are ignored when wr_valid = 0.

Reset
REQ-028 rst = 0 at a rising edge: state = IDLE, idx = 0, swap_done = 0, frame_err = 0.
REQ-029 Reset values of the active and shadow banks: b0_1 = b0_2 = 1<<COEFF_FRAC; all other coefficients = 0 (pass-through filter).
REQ-030 wr_ready = 0 and load_busy = 0 while rst = 0; wr_ready = 1 in the first cycle after release.
REQ-031 Reset mid-LOAD or mid-WAIT_TICK aborts the frame; no swap; outputs return to REQ-029 values.

Verification
REQ-032 Reset release -> b0_1 = b0_2 = 0x4000, others 0, wr_ready = 1, load_busy = 0.
REQ-033 Good frame of words 0x0101..0x010A back-to-back, then sample_tick 5 cycles later -> outputs unchanged until the tick edge; swap_done pulses once; b0_1 = 0x0101 ... a2_2 = 0x010A.
REQ-034 Same frame with wr_valid toggling 1/0 every cycle -> identical final bank; wr_ready = 0 only during WAIT_TICK.
REQ-035 wr_last on word 6 -> frame_err pulses once, state IDLE, active bank still at prior values; a following good frame plus tick commits correctly.
REQ-036 sample_tick coincident with word 10 -> no swap; swap occurs on the next tick; sample_tick during LOAD -> no output change.
REQ-037 rst = 0 asserted in WAIT_TICK before the tick -> outputs return to pass-through defaults; a later tick causes no swap and no swap_done.
